// File: rtl/lb_uart_receiver.sv
// UART receiver for the 11-bit frame: start, 8 data bits LSB first, parity, stop.
// Oversamples with a 16x baud tick and delivers each byte with a one-clk valid strobe.
module lb_uart_receiver #(
  parameter int OVERSAMPLE = 16,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       baud_tick16,
  input  logic       rx_in,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy
);

  localparam logic [3:0] MID_TICK  = 4'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0] LAST_TICK = 4'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t     state;
  state_t     state_next;
  logic       rx_meta;
  logic       rxs;
  logic [3:0] tick_cnt;
  logic [3:0] tick_inc;
  logic [2:0] bit_cnt;
  logic [7:0] shift_reg;
  logic       armed;
  logic       parity_mismatch;
  logic       start_det;
  logic       mid_pt;
  logic       sample_pt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx_in;
      rxs     <= rx_meta;
    end
  end

  assign tick_inc  = (tick_cnt == LAST_TICK) ? 4'd0 : tick_cnt + 4'd1;
  assign start_det = baud_tick16 && armed && !rxs;
  assign mid_pt    = baud_tick16 && (tick_cnt == MID_TICK);
  assign sample_pt = baud_tick16 && (tick_cnt == LAST_TICK);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A failed start check (line back high at mid start bit) is treated as a glitch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_det) state_next = START;
      START:   if (mid_pt) state_next = rxs ? IDLE : DATA;
      DATA:    if (sample_pt && (bit_cnt == 3'd7)) state_next = PARITY;
      PARITY:  if (sample_pt) state_next = STOP;
      STOP:    if (sample_pt) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
  end

  // armed only sets on a high line, so a break delivers a single frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick_cnt        <= 4'd0;
      bit_cnt         <= 3'd0;
      shift_reg       <= 8'h00;
      armed           <= 1'b1;
      parity_mismatch <= 1'b0;
      data_out        <= 8'h00;
      data_valid      <= 1'b0;
      parity_err      <= 1'b0;
      frame_err       <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (rxs) armed <= 1'b1;
          if (start_det) begin
            armed    <= 1'b0;
            tick_cnt <= 4'd0;
            bit_cnt  <= 3'd0;
          end
        end
        START: begin
          if (mid_pt) begin
            tick_cnt <= 4'd0;
          end else if (baud_tick16) begin
            tick_cnt <= tick_inc;
          end
        end
        DATA: begin
          if (baud_tick16) tick_cnt <= tick_inc;
          if (sample_pt) begin
            shift_reg <= {rxs, shift_reg[7:1]};
            bit_cnt   <= bit_cnt + 3'd1;
          end
        end
        PARITY: begin
          if (baud_tick16) tick_cnt <= tick_inc;
          if (sample_pt) parity_mismatch <= (rxs != (^shift_reg ^ PARITY_ODD));
        end
        STOP: begin
          if (baud_tick16) tick_cnt <= tick_inc;
          if (sample_pt) begin
            data_out   <= shift_reg;
            parity_err <= parity_mismatch;
            frame_err  <= ~rxs;
            data_valid <= 1'b1;
          end
        end
        default: begin
          tick_cnt <= 4'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lb_uart_receiver.sv
// Directed self-checking bench for lb_uart_receiver: clean, parity-error, break,
// glitch, mid-frame reset and back-to-back frames.
module tb_lb_uart_receiver;

  logic       clk;
  logic       reset;
  logic       baud_tick16;
  logic       rx_in;
  logic [7:0] data_out;
  logic       data_valid;
  logic       parity_err;
  logic       frame_err;
  logic       busy;

  int tests_run;
  int tests_failed;
  int valid_count;

  logic [7:0] cap_data [0:31];
  logic       cap_perr [0:31];
  logic       cap_ferr [0:31];

  lb_uart_receiver #(
    .OVERSAMPLE(16),
    .PARITY_ODD(1'b0)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .baud_tick16(baud_tick16),
    .rx_in      (rx_in),
    .data_out   (data_out),
    .data_valid (data_valid),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // One tick every 4 clk, driven on the falling edge.
  initial begin
    baud_tick16 = 1'b0;
    forever begin
      repeat (3) @(negedge clk);
      baud_tick16 = 1'b1;
      @(negedge clk);
      baud_tick16 = 1'b0;
    end
  end

  initial valid_count = 0;
  always @(negedge clk) begin
    if (data_valid === 1'b1) begin
      if (valid_count < 32) begin
        cap_data[valid_count] = data_out;
        cap_perr[valid_count] = parity_err;
        cap_ferr[valid_count] = frame_err;
      end
      valid_count = valid_count + 1;
    end
  end

  task automatic wait_ticks(input int n);
    repeat (n * 4) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    rx_in = b;
    wait_ticks(16);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(par);
    send_bit(stop);
    rx_in = 1'b1;
  endtask

  task automatic check_frame(input string name, input int idx, input logic [7:0] exp_d,
                             input logic exp_p, input logic exp_f);
    tests_run++;
    if (cap_data[idx] !== exp_d) begin
      tests_failed++;
      $display("[TB] FAIL %s data: got %h expected %h", name, cap_data[idx], exp_d);
    end
    tests_run++;
    if (cap_perr[idx] !== exp_p) begin
      tests_failed++;
      $display("[TB] FAIL %s parity_err: got %b expected %b", name, cap_perr[idx], exp_p);
    end
    tests_run++;
    if (cap_ferr[idx] !== exp_f) begin
      tests_failed++;
      $display("[TB] FAIL %s frame_err: got %b expected %b", name, cap_ferr[idx], exp_f);
    end
  endtask

  task automatic check_count(input string name, input int got, input int exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s valid count: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic test_reset();
    tests_run++;
    if ({data_out, data_valid, parity_err, frame_err, busy} !== 12'h000) begin
      tests_failed++;
      $display("[TB] FAIL reset outputs: got %h/%b/%b/%b/%b expected 00/0/0/0/0",
               data_out, data_valid, parity_err, frame_err, busy);
    end
  endtask

  task automatic test_clean_a5();
    int base;
    base = valid_count;
    send_frame(8'hA5, 1'b0, 1'b1);
    wait_ticks(32);
    check_count("a5", valid_count - base, 1);
    check_frame("a5", base, 8'hA5, 1'b0, 1'b0);
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL a5 busy after: got %b expected 0", busy);
    end
  endtask

  task automatic test_parity_error();
    int base;
    base = valid_count;
    send_frame(8'h07, 1'b0, 1'b1);
    wait_ticks(32);
    check_count("par07", valid_count - base, 1);
    check_frame("par07", base, 8'h07, 1'b1, 1'b0);
  endtask

  task automatic test_break();
    int base;
    base = valid_count;
    send_frame(8'h3C, 1'b0, 1'b0);
    rx_in = 1'b0;
    for (int i = 0; i < 40; i++) send_bit(1'b0);
    check_count("break", valid_count - base, 1);
    check_frame("break", base, 8'h3C, 1'b0, 1'b1);
    rx_in = 1'b1;
    wait_ticks(32);
    send_frame(8'h55, 1'b0, 1'b1);
    wait_ticks(32);
    check_count("after break", valid_count - base, 2);
    check_frame("after break", base + 1, 8'h55, 1'b0, 1'b0);
  endtask

  task automatic test_glitch();
    int base;
    base = valid_count;
    rx_in = 1'b0;
    wait_ticks(4);
    rx_in = 1'b1;
    tests_run++;
    if (busy !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL glitch busy pulse: got %b expected 1", busy);
    end
    wait_ticks(12);
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL glitch busy after: got %b expected 0", busy);
    end
    check_count("glitch", valid_count - base, 0);
    tests_run++;
    if (data_out !== 8'h55) begin
      tests_failed++;
      $display("[TB] FAIL glitch data_out held: got %h expected 55", data_out);
    end
    wait_ticks(16);
  endtask

  task automatic test_reset_midframe();
    int base;
    logic [7:0] f0;
    base = valid_count;
    f0 = 8'hF0;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(f0[i]);
    reset = 1'b0;
    rx_in = 1'b1;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({data_out, data_valid, parity_err, frame_err, busy} !== 12'h000) begin
      tests_failed++;
      $display("[TB] FAIL midframe reset outputs: got %h/%b/%b/%b/%b expected 00/0/0/0/0",
               data_out, data_valid, parity_err, frame_err, busy);
    end
    reset = 1'b1;
    wait_ticks(32);
    check_count("aborted frame", valid_count - base, 0);
    send_frame(8'h3C, 1'b0, 1'b1);
    wait_ticks(32);
    check_count("post reset", valid_count - base, 1);
    check_frame("post reset", base, 8'h3C, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    int base;
    base = valid_count;
    send_frame(8'h00, 1'b0, 1'b1);
    send_frame(8'hFF, 1'b0, 1'b1);
    wait_ticks(32);
    check_count("b2b", valid_count - base, 2);
    check_frame("b2b first", base, 8'h00, 1'b0, 1'b0);
    check_frame("b2b second", base + 1, 8'hFF, 1'b0, 1'b0);
    tests_run++;
    if (data_out !== 8'hFF) begin
      tests_failed++;
      $display("[TB] FAIL b2b data_out held: got %h expected ff", data_out);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset        = 1'b0;
    rx_in        = 1'b1;
    repeat (5) @(negedge clk);
    test_reset();
    reset = 1'b1;
    wait_ticks(20);
    test_clean_a5();
    test_parity_error();
    test_break();
    test_glitch();
    test_reset_midframe();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
